// File: rtl/vreg_load_if.sv
// vreg_load_if: handshake and write-port bundle for vreg_load_unit.
//
// Valid/ready semantics: a transfer happens on a rising clock edge where
// both valid and ready are high. The master may raise or drop valid at any
// time, and the slave samples its payload only on that edge. Ready is
// driven from slave state only and never depends on valid in the same cycle.
//
// Signals:
//   cfg_valid/cfg_ready/cfg_dest/cfg_count   burst request channel
//   word_valid/word_ready/word_data          data word channel
//   abort                                    synchronous burst cancel
//   wr_en/wr_sel/wr_data                     register file write port
//   busy/done/err                            status
//   state_dbg                                current FSM state (debug)
interface vreg_load_if #(
    parameter int WORDS = 8,
    parameter int SEL_W = 5,
    parameter int CNT_W = 4
);
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [SEL_W-1:0]      cfg_dest;
    logic [CNT_W-1:0]      cfg_count;
    logic                  word_valid;
    logic                  word_ready;
    logic [31:0]           word_data;
    logic                  abort;
    logic                  wr_en;
    logic [SEL_W-1:0]      wr_sel;
    logic [32*WORDS-1:0]   wr_data;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [1:0]            state_dbg;

    modport master (
        output cfg_valid, cfg_dest, cfg_count, word_valid, word_data, abort,
        input  cfg_ready, word_ready, wr_en, wr_sel, wr_data, busy, done, err,
               state_dbg
    );

    modport slave (
        input  cfg_valid, cfg_dest, cfg_count, word_valid, word_data, abort,
        output cfg_ready, word_ready, wr_en, wr_sel, wr_data, busy, done, err,
               state_dbg
    );
endinterface

// File: rtl/vreg_load_unit.sv
// vreg_load_unit: gathers a burst of 32-bit words into one 32*WORDS-bit
// vector and issues a single write to the vector register file.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-high reset
//   bus    vreg_load_if slave modport (cfg, word, abort, write port, status)
//
// States: IDLE (accept cfg), FILL (accept words), WRITE (one-cycle write).
// Every output is decoded from registered state, so no input reaches an
// output combinationally.
module vreg_load_unit #(
    parameter int WORDS = 8,
    parameter int SEL_W = 5,
    parameter int CNT_W = 4
) (
    input  logic        clk,
    input  logic        reset,
    vreg_load_if.slave  bus
);
    localparam int DATA_W = 32 * WORDS;
    localparam int IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t              state_q;
    logic [DATA_W-1:0]   buf_q;
    logic [IDX_W-1:0]    idx_q;
    logic [SEL_W-1:0]    dest_q;
    logic [CNT_W-1:0]    count_q;
    logic                err_q;

    logic                cfg_legal;
    logic                last_word;

    assign cfg_legal = (bus.cfg_count != '0) && (bus.cfg_count <= CNT_W'(WORDS));
    assign last_word = (CNT_W'(idx_q) == (count_q - CNT_W'(1)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            buf_q   <= '0;
            idx_q   <= '0;
            dest_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // A word offered alongside cfg is ignored; it must be
                    // re-offered once FILL is entered.
                    if (bus.cfg_valid) begin
                        if (cfg_legal) begin
                            dest_q  <= bus.cfg_dest;
                            count_q <= bus.cfg_count;
                            buf_q   <= '0;
                            idx_q   <= '0;
                            state_q <= S_FILL;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    // abort wins over a word offered in the same cycle.
                    if (bus.abort) begin
                        buf_q   <= '0;
                        idx_q   <= '0;
                        state_q <= S_IDLE;
                    end else if (bus.word_valid) begin
                        buf_q[32*int'(idx_q) +: 32] <= bus.word_data;
                        // The last word resets idx instead of incrementing,
                        // so idx stays within 0..WORDS-1.
                        if (last_word) begin
                            idx_q   <= '0;
                            state_q <= S_WRITE;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                S_WRITE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cfg_ready  = (state_q == S_IDLE);
    assign bus.word_ready = (state_q == S_FILL);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.wr_en      = (state_q == S_WRITE);
    assign bus.done       = (state_q == S_WRITE);
    assign bus.wr_sel     = dest_q;
    // Buffer contents are only exposed during the write cycle.
    assign bus.wr_data    = (state_q == S_WRITE) ? buf_q : '0;
    assign bus.err        = err_q;
    assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_vreg_load_unit.sv
module tb_vreg_load_unit;
    localparam int WORDS = 8;
    localparam int SEL_W = 5;
    localparam int CNT_W = 4;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   wr_pulses;

    vreg_load_if #(.WORDS(WORDS), .SEL_W(SEL_W), .CNT_W(CNT_W)) bus ();

    vreg_load_unit #(.WORDS(WORDS), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) wr_pulses++;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.cfg_valid  = 1'b0;
        bus.cfg_dest   = '0;
        bus.cfg_count  = '0;
        bus.word_valid = 1'b0;
        bus.word_data  = '0;
        bus.abort      = 1'b0;
    endtask

    task automatic send_cfg(input logic [SEL_W-1:0] dest, input logic [CNT_W-1:0] cnt);
        bus.cfg_valid = 1'b1;
        bus.cfg_dest  = dest;
        bus.cfg_count = cnt;
        tick();
        bus.cfg_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] data);
        bus.word_valid = 1'b1;
        bus.word_data  = data;
        tick();
        bus.word_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cfg_ready"},  256'(bus.cfg_ready),  256'(1));
        check({tag, "_word_ready"}, 256'(bus.word_ready), 256'(0));
        check({tag, "_wr_en"},      256'(bus.wr_en),      256'(0));
        check({tag, "_wr_sel"},     256'(bus.wr_sel),     256'(0));
        check({tag, "_wr_data"},    256'(bus.wr_data),    256'(0));
        check({tag, "_busy"},       256'(bus.busy),       256'(0));
        check({tag, "_done"},       256'(bus.done),       256'(0));
        check({tag, "_err"},        256'(bus.err),        256'(0));
    endtask

    initial begin
        logic [255:0] exp_data;
        logic [6:0]   pat;
        int           k;

        checks    = 0;
        errors    = 0;
        wr_pulses = 0;
        reset     = 1'b1;
        idle_inputs();
        tick();
        tick();
        check_reset_outputs("reset");
        reset = 1'b0;
        tick();

        // Full 8-word burst, bytes 0x00..0x1F ascending
        send_cfg(5'd3, 4'd8);
        check("t1_busy", 256'(bus.busy), 256'(1));
        check("t1_word_ready", 256'(bus.word_ready), 256'(1));
        check("t1_cfg_ready", 256'(bus.cfg_ready), 256'(0));
        for (int i = 0; i < 8; i++) begin
            check("t1_no_early_wr", 256'(bus.wr_en), 256'(0));
            send_word({8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});
        end
        exp_data = '0;
        for (int b = 0; b < 32; b++) exp_data[8*b +: 8] = 8'(b);
        check("t1_wr_en", 256'(bus.wr_en), 256'(1));
        check("t1_done", 256'(bus.done), 256'(1));
        check("t1_wr_sel", 256'(bus.wr_sel), 256'(3));
        check("t1_wr_data", bus.wr_data, exp_data);
        check("t1_word_ready_wr", 256'(bus.word_ready), 256'(0));
        tick();
        check("t1_after_wr_en", 256'(bus.wr_en), 256'(0));
        check("t1_after_data", bus.wr_data, 256'(0));
        check("t1_after_cfg_ready", 256'(bus.cfg_ready), 256'(1));
        check("t1_sel_held", 256'(bus.wr_sel), 256'(3));

        // Short burst with zero fill
        send_cfg(5'd7, 4'd2);
        send_word(32'hDEADBEEF);
        send_word(32'h12345678);
        check("t2_wr_en", 256'(bus.wr_en), 256'(1));
        check("t2_wr_sel", 256'(bus.wr_sel), 256'(7));
        check("t2_wr_data", bus.wr_data, {192'd0, 64'h12345678_DEADBEEF});
        tick();

        // Illegal counts
        send_cfg(5'd2, 4'd0);
        check("t3_err0", 256'(bus.err), 256'(1));
        check("t3_cfg_ready0", 256'(bus.cfg_ready), 256'(1));
        check("t3_busy0", 256'(bus.busy), 256'(0));
        tick();
        check("t3_err0_clear", 256'(bus.err), 256'(0));
        send_cfg(5'd2, 4'd9);
        check("t3_err9", 256'(bus.err), 256'(1));
        check("t3_cfg_ready9", 256'(bus.cfg_ready), 256'(1));
        tick();
        check("t3_err9_clear", 256'(bus.err), 256'(0));
        check("t3_wr_en", 256'(bus.wr_en), 256'(0));

        // Backpressure: valid pattern 1,0,0,1,1,0,1 (LSB first)
        send_cfg(5'd5, 4'd4);
        pat = 7'b1011001;
        k = 0;
        for (int p = 0; p < 7; p++) begin
            bus.word_valid = pat[p];
            bus.word_data  = pat[p] ? (32'hA0000000 | 32'(k)) : 32'hBAD0BAD0;
            if (pat[p]) k++;
            tick();
            if (p < 6) check("t4_no_early_wr", 256'(bus.wr_en), 256'(0));
        end
        bus.word_valid = 1'b0;
        check("t4_wr_en", 256'(bus.wr_en), 256'(1));
        check("t4_wr_sel", 256'(bus.wr_sel), 256'(5));
        check("t4_wr_data", bus.wr_data,
              {128'd0, 32'hA0000003, 32'hA0000002, 32'hA0000001, 32'hA0000000});
        tick();

        // Abort after 3 words, abort wins over a same-cycle word
        send_cfg(5'd2, 4'd8);
        send_word(32'h11111111);
        send_word(32'h22222222);
        send_word(32'h33333333);
        bus.abort      = 1'b1;
        bus.word_valid = 1'b1;
        bus.word_data  = 32'h44444444;
        tick();
        bus.abort      = 1'b0;
        bus.word_valid = 1'b0;
        check("t5_abort_idle", 256'(bus.cfg_ready), 256'(1));
        check("t5_abort_busy", 256'(bus.busy), 256'(0));
        check("t5_abort_wr_en", 256'(bus.wr_en), 256'(0));
        check("t5_abort_done", 256'(bus.done), 256'(0));
        // cfg and word together in IDLE: word must be dropped
        bus.word_valid = 1'b1;
        bus.word_data  = 32'h00000055;
        send_cfg(5'd1, 4'd1);
        bus.word_valid = 1'b0;
        check("t5_fill_after_cfg", 256'(bus.word_ready), 256'(1));
        check("t5_no_wr_yet", 256'(bus.wr_en), 256'(0));
        send_word(32'h000000AA);
        check("t5_wr_en", 256'(bus.wr_en), 256'(1));
        check("t5_wr_sel", 256'(bus.wr_sel), 256'(1));
        check("t5_wr_data", bus.wr_data, 256'h0AA);
        tick();

        // Reset mid-FILL
        send_cfg(5'd4, 4'd8);
        for (int i = 0; i < 5; i++) send_word(32'hC0DE0000 | 32'(i));
        check("t6_busy_pre", 256'(bus.busy), 256'(1));
        #3 reset = 1'b1;
        #1 check_reset_outputs("t6_fill_rst");
        tick();
        reset = 1'b0;
        tick();

        // Reset mid-WRITE: wr_en must drop before the next edge
        send_cfg(5'd6, 4'd1);
        send_word(32'h00000077);
        check("t6_wr_en_pre", 256'(bus.wr_en), 256'(1));
        #3 reset = 1'b1;
        #1 check_reset_outputs("t6_write_rst");
        tick();
        reset = 1'b0;
        tick();

        // Fresh burst after reset
        send_cfg(5'd9, 4'd3);
        send_word(32'h00000001);
        send_word(32'h00000002);
        send_word(32'h00000003);
        check("t6_fresh_wr_en", 256'(bus.wr_en), 256'(1));
        check("t6_fresh_wr_sel", 256'(bus.wr_sel), 256'(9));
        check("t6_fresh_wr_data", bus.wr_data, {160'd0, 32'd3, 32'd2, 32'd1});
        tick();
        check("t6_fresh_idle", 256'(bus.cfg_ready), 256'(1));
        tick();

        // t1, t2, t4, t5 second burst, mid-WRITE reset cycle, fresh burst
        check("wr_pulse_total", 256'(wr_pulses), 256'(6));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
